// File: rtl/spi_pixel_streamer.sv
// SPI-memory read master: sends READ command + address, deserialises MISO into
// pixel words and queues them in a show-ahead FIFO, stalling SCLK while the FIFO is full.
module spi_pixel_streamer #(
    parameter int unsigned PIXEL_BITS = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_BITS  = 24,
    parameter logic [7:0]  READ_CMD   = 8'h03,
    parameter int unsigned COUNT_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  start_addr,
    input  logic [COUNT_W-1:0]    word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    input  logic                  pop,
    output logic [PIXEL_BITS-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  underrun,
    output logic                  spi_cs,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ShW = 8 + ADDR_BITS;
    localparam int unsigned BcW = $clog2(ShW + PIXEL_BITS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StAddr   = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StStall  = 3'd4;
    localparam logic [2:0] StFinish = 3'd5;

    localparam logic [BcW-1:0]     BcOne    = BcW'(1);
    localparam logic [BcW-1:0]     CmdLast  = BcW'(7);
    localparam logic [BcW-1:0]     AddrLast = BcW'(ADDR_BITS - 1);
    localparam logic [BcW-1:0]     PixLast  = BcW'(PIXEL_BITS - 1);
    localparam logic [COUNT_W-1:0] OneWord  = COUNT_W'(1);
    localparam logic [AW:0]        FillOne  = (AW + 1)'(1);
    localparam logic [AW:0]        Full     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]      PtrOne   = AW'(1);

    logic [2:0]            state_q, state_d;
    logic                  phase_q, phase_d;
    logic [BcW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ShW-1:0]        sh_q, sh_d;
    logic [PIXEL_BITS-2:0] pix_sh_q, pix_sh_d;
    logic [COUNT_W-1:0]    words_q, words_d;
    logic                  underrun_q;

    logic [PIXEL_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic [AW:0]           fill_next;

    logic                  abort_go;
    logic                  pop_ok;
    logic                  word_done;
    logic                  push;
    logic [PIXEL_BITS-1:0] push_data;
    logic                  flush;
    logic                  clr_underrun;

    // Abort outranks start and pop; it is a no-op while idle.
    assign abort_go  = abort && (state_q != StIdle);
    assign pop_ok    = pop && (count_q != '0) && !abort_go;
    assign word_done = (state_q == StData) && phase_q && (bit_cnt_q == PixLast);
    assign push      = word_done && !abort_go;
    assign push_data = {pix_sh_q, spi_miso};

    // FIFO occupancy after this edge; the stall decision uses it so a push landing
    // on the same edge is already accounted for.
    always_comb begin
        fill_next = count_q;
        if (push && !pop_ok) begin
            fill_next = count_q + FillOne;
        end else if (!push && pop_ok) begin
            fill_next = count_q - FillOne;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        pix_sh_d     = pix_sh_q;
        words_d      = words_q;
        flush        = 1'b0;
        clr_underrun = 1'b0;

        if (abort_go) begin
            state_d   = StIdle;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            flush     = 1'b1;
        end else begin
            case (state_q)
                StIdle, StFinish: begin
                    state_d = StIdle;
                    if (start) begin
                        if (word_count == '0) begin
                            state_d = StFinish;
                        end else begin
                            state_d      = StCmd;
                            phase_d      = 1'b0;
                            bit_cnt_d    = '0;
                            sh_d         = {READ_CMD, start_addr};
                            words_d      = word_count;
                            flush        = 1'b1;
                            clr_underrun = 1'b1;
                        end
                    end
                end
                StCmd: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sh_d    = {sh_q[ShW-2:0], 1'b0};
                        if (bit_cnt_q == CmdLast) begin
                            bit_cnt_d = '0;
                            state_d   = StAddr;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BcOne;
                        end
                    end
                end
                StAddr: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sh_d    = {sh_q[ShW-2:0], 1'b0};
                        if (bit_cnt_q == AddrLast) begin
                            bit_cnt_d = '0;
                            state_d   = (fill_next == Full) ? StStall : StData;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BcOne;
                        end
                    end
                end
                StData: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        pix_sh_d = (PIXEL_BITS - 1)'({pix_sh_q, spi_miso});
                        if (bit_cnt_q == PixLast) begin
                            bit_cnt_d = '0;
                            words_d   = words_q - OneWord;
                            if (words_q == OneWord) begin
                                state_d = StFinish;
                            end else begin
                                state_d = (fill_next == Full) ? StStall : StData;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BcOne;
                        end
                    end
                end
                StStall: begin
                    if (fill_next != Full) begin
                        state_d = StData;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            pix_sh_q  <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            pix_sh_q  <= pix_sh_d;
            words_q   <= words_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else if (clr_underrun) begin
            underrun_q <= 1'b0;
        end else if (pop && (count_q == '0) && !abort_go) begin
            underrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= fill_next;
        end
    end

    always_comb begin
        busy     = (state_q == StCmd) || (state_q == StAddr) ||
                   (state_q == StData) || (state_q == StStall);
        spi_cs   = busy;
        spi_sclk = phase_q &&
                   ((state_q == StCmd) || (state_q == StAddr) || (state_q == StData));
        spi_mosi = ((state_q == StCmd) || (state_q == StAddr)) && sh_q[ShW-1];
        done     = (state_q == StFinish);
    end

    assign pix_data  = mem_q[rd_ptr_q];
    assign pix_valid = (count_q != '0);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_pixel_streamer.sv
// Bench for spi_pixel_streamer: directed transfers against a bit-level SPI slave,
// with a pixel scoreboard and a MOSI stream monitor.
module tb_spi_pixel_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, abort, pop;
    logic [23:0] start_addr;
    logic [9:0]  word_count;
    logic        busy, done, pix_valid, underrun;
    logic [8:0]  pix_data;
    logic        spi_cs, spi_sclk, spi_mosi, spi_miso;

    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;
    int          mosi_checks = 0;
    int          scnt;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_pix;
    logic [31:0] exp_stream = '0;
    logic [8:0]  tx_words [8];

    always #5 clk = ~clk;

    spi_pixel_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pop        (pop),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .underrun   (underrun),
        .spi_cs     (spi_cs),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI slave: counts completed SCLK pulses; data bits follow the 32 command/address bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt <= 0;
        else if (!spi_cs) scnt <= 0;
        else if (spi_sclk) scnt <= scnt + 1;
    end

    always_comb begin
        int d;
        d = scnt - 32;
        spi_miso = 1'b0;
        if (scnt >= 32 && d < 72) spi_miso = tx_words[d / 9][8 - (d % 9)];
    end

    // Monitor: pixel scoreboard, MOSI stream, done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            if (pop && pix_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pixel_unexpected: got %0h expected none", pix_data);
                end else begin
                    exp_pix = exp_q.pop_front();
                    check("pixel", {23'd0, pix_data}, {23'd0, exp_pix});
                end
            end
            if (spi_cs && spi_sclk) begin
                if (scnt < 32) begin
                    check("mosi_bit", {31'd0, spi_mosi}, {31'd0, exp_stream[31 - scnt]});
                    mosi_checks++;
                end else begin
                    check("mosi_data_low", {31'd0, spi_mosi}, 32'd0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called in cycle 0; returns in cycle 1.
    task automatic issue(input logic [23:0] a, input logic [9:0] n);
        start       = 1'b1;
        start_addr  = a;
        word_count  = n;
        exp_stream  = {8'h03, a};
        mosi_checks = 0;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; pop = 1'b0; start_addr = '0; word_count = '0;
        for (int i = 0; i < 8; i++) tx_words[i] = '0;

        tick(2);
        check("reset_outputs",
              {19'd0, busy, done, pix_valid, underrun, spi_cs, spi_sclk, spi_mosi, pix_data}, 0);
        rst_n = 1'b1;
        tick(1);
        check("idle_outputs",
              {19'd0, busy, done, pix_valid, underrun, spi_cs, spi_sclk, spi_mosi, pix_data}, 0);

        // Pop on empty FIFO
        pop = 1'b1; tick(1); pop = 1'b0;
        check("underrun_set", underrun, 1);
        check("underrun_valid", pix_valid, 0);
        tick(1);
        check("underrun_sticky", underrun, 1);

        // Single word transfer
        tx_words[0] = 9'h1A5;
        exp_q.push_back(9'h1A5);
        issue(24'h123456, 10'd1);
        check("t1_c1_busy_cs_sclk", {busy, spi_cs, spi_sclk}, 3'b110);
        check("t1_underrun_clr", underrun, 0);
        tick(1);
        check("t1_c2_sclk", spi_sclk, 1);
        tick(80);
        check("t1_c82", {done, pix_valid, spi_cs}, 3'b001);
        tick(1);
        check("t1_c83_ctrl", {pix_valid, done, spi_cs, busy}, 4'b1100);
        check("t1_c83_data", pix_data, 9'h1A5);
        check("t1_mosi_bits", mosi_checks, 32);
        tick(1);
        check("t1_done_once", done, 0);
        pop = 1'b1; tick(1); pop = 1'b0;
        check("t1_drained", pix_valid, 0);

        // Zero-length transfer
        issue(24'h000000, 10'd0);
        check("wc0_c1", {done, spi_cs, busy}, 3'b100);
        tick(1);
        check("wc0_c2", {done, spi_cs, busy}, 3'b000);

        // Six words, FIFO fills, stall, push+pop at count 3
        tx_words[0] = 9'h001; tx_words[1] = 9'h0AA; tx_words[2] = 9'h155;
        tx_words[3] = 9'h1FF; tx_words[4] = 9'h100; tx_words[5] = 9'h07E;
        for (int i = 0; i < 6; i++) exp_q.push_back(tx_words[i]);
        issue(24'h000100, 10'd6);
        tick(136);
        check("t4_stall_c137", {spi_sclk, spi_cs, busy, pix_valid}, 4'b0111);
        tick(3);
        start = 1'b1; word_count = 10'd0; tick(1); start = 1'b0;
        check("t4_busy_start_ignored", {busy, done, spi_cs}, 3'b101);
        tick(1);
        check("t4_no_done", {done, busy, spi_sclk}, 3'b010);
        tick(5);
        check("t4_stall_c147", {spi_sclk, spi_cs}, 2'b01);
        pop = 1'b1; tick(1); pop = 1'b0;
        check("t4_resume_phase0", {spi_sclk, spi_cs}, 2'b01);
        tick(1);
        check("t4_resume_sclk", spi_sclk, 1);
        tick(16);
        pop = 1'b1; tick(1); pop = 1'b0;
        check("t4_pushpop_phase0", spi_sclk, 0);
        tick(1);
        check("t4_no_stall_after_pushpop", spi_sclk, 1);
        tick(16);
        check("t4_c183", done, 0);
        tick(1);
        check("t4_done", {done, spi_cs, busy, pix_valid}, 4'b1001);
        pop = 1'b1; tick(4); pop = 1'b0;
        check("t4_empty", pix_valid, 0);
        check("t4_all_words", exp_q.size(), 0);

        // Abort in ADDR bit 10, then immediate restart
        issue(24'hFEDCBA, 10'd2);
        tick(36);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort_next", {spi_cs, spi_sclk, busy, done, pix_valid}, 5'b00000);
        check("abort_bits_sent", mosi_checks, 18);
        tick(1);
        check("abort_no_done", done, 0);
        tx_words[0] = 9'h0F0;
        exp_q.push_back(9'h0F0);
        issue(24'hABCDEF, 10'd1);
        check("restart_cs", spi_cs, 1);
        tick(82);
        check("restart_done", {done, pix_valid}, 2'b11);
        check("restart_data", pix_data, 9'h0F0);
        check("restart_mosi_bits", mosi_checks, 32);
        pop = 1'b1; tick(1); pop = 1'b0;
        tick(2);

        check("done_pulses", done_seen, 4);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_pixel_streamer.md
# spi_pixel_streamer

Parametrised SPI-memory read master that streams packed pixel words into a small show-ahead FIFO for the VGA pixel pipeline. It issues a standard serial READ (command + address), deserialises MISO into PIXEL_BITS-wide words, and stalls SCLK whenever the FIFO is full. It sits between the SPI pins in the top level and the VGA RGB output stage.

## Interface
- PIXEL_BITS, 9: bits per pixel word (RGB333 by default), MSB received first.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_BITS, 24: address bits sent after the command, MSB first.
- READ_CMD, 8'h03: 8-bit command byte, MSB first.
- COUNT_W, 10: width of word_count.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only when busy=0.
- start_addr  in  ADDR_BITS  byte address, sampled with start.
- word_count  in  COUNT_W  number of words to read, sampled with start.
- abort  in  1  terminates the current transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at normal completion.
- pop  in  1  consumer takes the FIFO head this cycle.
- pix_data  out  PIXEL_BITS  FIFO head (show-ahead).
- pix_valid  out  1  FIFO non-empty.
- underrun  out  1  sticky: pop seen while pix_valid=0.
- spi_cs  out  1  chip select, active HIGH (top level inverts to /CS).
- spi_sclk  out  1  SPI clock, idle low (mode 0).
- spi_mosi  out  1  serial command/address out.
- spi_miso  in  1  serial data in.

## Operation
- States: IDLE, CMD, ADDR, DATA, STALL, FINISH.
- IDLE: cs=0, sclk=0, mosi=0.
  - start with word_count=0: done pulses next cycle; CS is never asserted.
  - start with word_count>0: FIFO is flushed, underrun clears, and the block moves to CMD.
- Each SPI bit takes two clk cycles.
  - Phase 0: sclk=0, mosi holds the bit.
  - Phase 1: sclk=1; MISO is sampled on the clk edge that ends phase 1.
- CMD sends the 8 command bits, then ADDR sends ADDR_BITS. mosi=0 during DATA.
- DATA shifts MISO in MSB first. The PIXEL_BITS-th sample pushes the assembled word.
- Before phase 0 of each word's first bit: if the FIFO count equals FIFO_DEPTH, go to STALL.
  - STALL holds sclk=0 and cs=1.
  - STALL resumes in the cycle after the count drops below FIFO_DEPTH.
  - This guarantees every push fits.
- After the final word is pushed: FINISH for one cycle (cs=0, done=1, busy=0), then IDLE.
- Push and pop in the same cycle leave the count unchanged and keep FIFO order.
- pop with pix_valid=0 is ignored and sets underrun. underrun clears only on an accepted start.
- abort (any non-IDLE state):
  - Next cycle: cs=0, sclk=0, state IDLE, partial word discarded, FIFO flushed, no done pulse.
  - abort has priority over start and pop.
- start while busy=1 is ignored.
- The FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset: every output is 0 (busy, done, pix_valid, pix_data, underrun, spi_cs, spi_sclk, spi_mosi). Reset also clears the FIFO and the state. Asserting reset mid-transfer drops cs asynchronously.
- Cycle numbering: start is sampled at the end of cycle 0. Stream bit k (0-based, command first) occupies cycles 1+2k (sclk low) and 2+2k (sclk high).
- busy and cs rise in cycle 1. The first sclk rise is in cycle 2.
- The command plus address take 2·(8+ADDR_BITS) cycles. With the defaults this is 64 cycles, covering cycles 1–64.
- Without stalls (defaults), word n (0-based) is pushed at the end of cycle 64+18(n+1).
  - pix_valid rises in cycle 83 for word 0.
  - For N words, done pulses in cycle 65+18N, together with cs=0 and busy=0.
- Stall: if the FIFO goes not-full at the end of cycle t, phase 0 resumes in cycle t+1 and sclk rises in cycle t+2.
- Pop latency: the next head appears on pix_data in the cycle after pop.

## Test plan
- Defaults, addr=0x123456, word_count=1, MISO serves 9'h1A5.
  - MOSI must equal 0x03 then 0x123456, MSB first, on sclk rises in cycles 2–64.
  - pix_data=9'h1A5 and pix_valid=1 in cycle 83; done in cycle 83; cs=0 in cycle 83.
- word_count=6 with no pops: exactly 4 words are pushed, then sclk stays low and cs high.
  - Pop once: sclk rises 2 cycles after the pop edge; 6 words arrive in order; done fires after the last word.
- pop with the FIFO empty after reset: underrun=1 and pix_valid stays 0. A later accepted start clears underrun.
- abort during ADDR bit 10: next cycle cs=0, sclk=0, busy=0; no done pulse; FIFO empty.
  - An immediate restart must replay the full command and address.
- word_count=0: done pulses in cycle 1 and cs never rises.
- A push coinciding with a pop while the count is 3: the count stays 3 and word order is preserved. A second start issued while busy=1 is ignored.
